// File: rtl/multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// multicycle_ctrl -- control FSM, condition check and flags for a multicycle ARM-subset core
// Revision: 1.0
// ============================================================================
module multicycle_ctrl #(
    parameter logic [3:0] FLAG_RESET = 4'b0000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] Cond,
    input  logic [1:0] Op,
    input  logic [5:0] Funct,
    input  logic [3:0] Rd,
    input  logic [3:0] ALUFlags,
    input  logic       mem_rdy,
    output logic       PCWrite,
    output logic       MemWrite,
    output logic       RegWrite,
    output logic       IRWrite,
    output logic       AdrSrc,
    output logic       ALUSrcA,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ImmSrc,
    output logic [1:0] RegSrc,
    output logic [1:0] ALUControl,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXECR  = 4'd6,
        EXECI  = 4'd7,
        ALUWB  = 4'd8,
        BRANCH = 4'd9
    } state_t;

    state_t     r_state;
    state_t     w_next;
    logic [3:0] r_flags;
    logic       cond_q;
    logic       w_cond_ex;
    logic [1:0] w_alu_dec;
    logic       w_arith;
    logic       w_exec;

    logic [3:0] w_cmd;
    logic       w_n, w_z, w_c, w_v;

    assign w_cmd = Funct[4:1];
    assign {w_n, w_z, w_c, w_v} = r_flags;
    assign w_exec = (r_state == EXECR) || (r_state == EXECI);
    assign state  = r_state;

    always_comb begin
        w_cond_ex = 1'b0;
        case (Cond)
            4'b0000: w_cond_ex = w_z;
            4'b0001: w_cond_ex = !w_z;
            4'b0010: w_cond_ex = w_c;
            4'b0011: w_cond_ex = !w_c;
            4'b0100: w_cond_ex = w_n;
            4'b0101: w_cond_ex = !w_n;
            4'b0110: w_cond_ex = w_v;
            4'b0111: w_cond_ex = !w_v;
            4'b1000: w_cond_ex = w_c && !w_z;
            4'b1001: w_cond_ex = !w_c || w_z;
            4'b1010: w_cond_ex = (w_n == w_v);
            4'b1011: w_cond_ex = (w_n != w_v);
            4'b1100: w_cond_ex = !w_z && (w_n == w_v);
            4'b1101: w_cond_ex = w_z || (w_n != w_v);
            4'b1110: w_cond_ex = 1'b1;
            default: w_cond_ex = 1'b0;
        endcase
    end

    always_comb begin
        w_alu_dec = 2'b00;
        w_arith   = 1'b0;
        case (w_cmd)
            4'b0100: begin w_alu_dec = 2'b00; w_arith = 1'b1; end
            4'b0010: begin w_alu_dec = 2'b01; w_arith = 1'b1; end
            4'b0000: w_alu_dec = 2'b10;
            4'b1100: w_alu_dec = 2'b11;
            default: w_alu_dec = 2'b00;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= FETCH;
            r_flags <= FLAG_RESET;
            cond_q  <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == DECODE)
                cond_q <= w_cond_ex;
            // C and V only carry meaning for arithmetic ops; logical ops keep them
            if (w_exec && cond_q && Funct[0]) begin
                r_flags[3:2] <= ALUFlags[3:2];
                if (w_arith)
                    r_flags[1:0] <= ALUFlags[1:0];
            end
        end
    end

    always_comb begin
        w_next = FETCH;
        case (r_state)
            FETCH:   w_next = mem_rdy ? DECODE : FETCH;
            DECODE: begin
                case (Op)
                    2'b01:   w_next = MEMADR;
                    2'b00:   w_next = Funct[5] ? EXECI : EXECR;
                    2'b10:   w_next = BRANCH;
                    default: w_next = FETCH;
                endcase
            end
            MEMADR:  w_next = Funct[0] ? MEMRD : MEMWR;
            MEMRD:   w_next = mem_rdy ? MEMWB : MEMRD;
            MEMWR:   w_next = mem_rdy ? FETCH : MEMWR;
            EXECR:   w_next = ALUWB;
            EXECI:   w_next = ALUWB;
            default: w_next = FETCH;
        endcase
    end

    always_comb begin
        PCWrite    = 1'b0;
        MemWrite   = 1'b0;
        RegWrite   = 1'b0;
        IRWrite    = 1'b0;
        AdrSrc     = 1'b0;
        ALUSrcA    = 1'b0;
        ResultSrc  = 2'b00;
        ALUSrcB    = 2'b00;
        ALUControl = 2'b00;
        ImmSrc     = Op;
        RegSrc     = {Op == 2'b01, Op == 2'b10};
        case (r_state)
            FETCH: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                // state reads FETCH during reset, so the handshake is masked
                IRWrite   = mem_rdy && reset_n;
                PCWrite   = mem_rdy && reset_n;
            end
            DECODE: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
            end
            MEMADR: ALUSrcB = 2'b01;
            MEMRD:  AdrSrc  = 1'b1;
            MEMWR: begin
                AdrSrc   = 1'b1;
                MemWrite = cond_q;
            end
            MEMWB: begin
                ResultSrc = 2'b01;
                RegWrite  = cond_q;
                PCWrite   = cond_q && (Rd == 4'b1111);
            end
            EXECR:  ALUControl = w_alu_dec;
            EXECI: begin
                ALUSrcB    = 2'b01;
                ALUControl = w_alu_dec;
            end
            ALUWB: begin
                RegWrite = cond_q;
                PCWrite  = cond_q && (Rd == 4'b1111);
            end
            BRANCH: begin
                ALUSrcB   = 2'b01;
                ResultSrc = 2'b10;
                PCWrite   = cond_q;
            end
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
`default_nettype none
// Directed bench for multicycle_ctrl: per-cycle expectations go through a scoreboard queue.
module tb_multicycle_ctrl;

    logic       clk;
    logic       reset_n;
    logic [3:0] Cond;
    logic [1:0] Op;
    logic [5:0] Funct;
    logic [3:0] Rd;
    logic [3:0] ALUFlags;
    logic       mem_rdy;
    logic       PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, ALUSrcA;
    logic [1:0] ResultSrc, ALUSrcB, ImmSrc, RegSrc, ALUControl;
    logic [3:0] state;

    int compared = 0;
    int mismatched = 0;

    typedef struct packed {
        logic [3:0] st;
        logic       pcw;
        logic       rw;
        logic       mw;
        logic       irw;
        logic [1:0] aluc;
    } exp_t;

    exp_t sb[$];

    multicycle_ctrl #(.FLAG_RESET(4'b0000)) dut (
        .clk(clk), .reset_n(reset_n), .Cond(Cond), .Op(Op), .Funct(Funct),
        .Rd(Rd), .ALUFlags(ALUFlags), .mem_rdy(mem_rdy),
        .PCWrite(PCWrite), .MemWrite(MemWrite), .RegWrite(RegWrite),
        .IRWrite(IRWrite), .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA),
        .ResultSrc(ResultSrc), .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc),
        .RegSrc(RegSrc), .ALUControl(ALUControl), .state(state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_instr(input logic [3:0] c, input logic [1:0] o,
                             input logic [5:0] f, input logic [3:0] r);
        Cond  = c;
        Op    = o;
        Funct = f;
        Rd    = r;
    endtask

    // Called just after a falling edge with inputs already set: check mid-cycle, then advance.
    task automatic cyc(input string tag, input logic [3:0] st, input logic pcw,
                       input logic rw, input logic mw, input logic irw, input logic [1:0] aluc);
        exp_t e;
        sb.push_back({st, pcw, rw, mw, irw, aluc});
        #2;
        e = sb.pop_front();
        chk({tag, ".state"},      state,              e.st);
        chk({tag, ".PCWrite"},    {3'b000, PCWrite},  {3'b000, e.pcw});
        chk({tag, ".RegWrite"},   {3'b000, RegWrite}, {3'b000, e.rw});
        chk({tag, ".MemWrite"},   {3'b000, MemWrite}, {3'b000, e.mw});
        chk({tag, ".IRWrite"},    {3'b000, IRWrite},  {3'b000, e.irw});
        chk({tag, ".ALUControl"}, {2'b00, ALUControl}, {2'b00, e.aluc});
        @(negedge clk);
    endtask

    initial begin
        reset_n  = 1'b0;
        mem_rdy  = 1'b1;
        ALUFlags = 4'b0000;
        set_instr(4'b1110, 2'b00, 6'b000000, 4'd0);
        #2;
        chk("rst.state",   state,              4'd0);
        chk("rst.IRWrite", {3'b000, IRWrite},  4'd0);
        chk("rst.PCWrite", {3'b000, PCWrite},  4'd0);
        chk("rst.selB",    {2'b00, ALUSrcB},   4'b0010);
        chk("rst.result",  {2'b00, ResultSrc}, 4'b0010);
        chk("rst.srcA",    {3'b000, ALUSrcA},  4'd1);
        @(negedge clk);
        reset_n = 1'b1;

        // STREQ with Z=0: full path, no write
        set_instr(4'b0000, 2'b01, 6'b011000, 4'd3);
        cyc("streq.f", 4'd0, 1, 0, 0, 1, 2'b00);
        chk("streq.imm", {2'b00, ImmSrc}, 4'b0001);
        chk("streq.reg", {2'b00, RegSrc}, 4'b0010);
        cyc("streq.d", 4'd1, 0, 0, 0, 0, 2'b00);
        cyc("streq.a", 4'd2, 0, 0, 0, 0, 2'b00);
        cyc("streq.w", 4'd5, 0, 0, 0, 0, 2'b00);

        // ADDS R1,R2,R3 -> flags 0110
        set_instr(4'b1110, 2'b00, 6'b001001, 4'd1);
        ALUFlags = 4'b0110;
        cyc("adds.f", 4'd0, 1, 0, 0, 1, 2'b00);
        cyc("adds.d", 4'd1, 0, 0, 0, 0, 2'b00);
        cyc("adds.x", 4'd6, 0, 0, 0, 0, 2'b00);
        ALUFlags = 4'b0000;
        cyc("adds.wb", 4'd8, 0, 1, 0, 0, 2'b00);

        // BNE with Z=1: not taken
        set_instr(4'b0001, 2'b10, 6'b000000, 4'd0);
        cyc("bne.f", 4'd0, 1, 0, 0, 1, 2'b00);
        cyc("bne.d", 4'd1, 0, 0, 0, 0, 2'b00);
        cyc("bne.b", 4'd9, 0, 0, 0, 0, 2'b00);

        // B always
        set_instr(4'b1110, 2'b10, 6'b000000, 4'd0);
        cyc("b.f", 4'd0, 1, 0, 0, 1, 2'b00);
        cyc("b.d", 4'd1, 0, 0, 0, 0, 2'b00);
        cyc("b.b", 4'd9, 1, 0, 0, 0, 2'b00);

        // LDR with two wait cycles in MEMRD
        set_instr(4'b1110, 2'b01, 6'b011001, 4'd2);
        cyc("ldr.f", 4'd0, 1, 0, 0, 1, 2'b00);
        cyc("ldr.d", 4'd1, 0, 0, 0, 0, 2'b00);
        cyc("ldr.a", 4'd2, 0, 0, 0, 0, 2'b00);
        mem_rdy = 1'b0;
        cyc("ldr.r0", 4'd3, 0, 0, 0, 0, 2'b00);
        cyc("ldr.r1", 4'd3, 0, 0, 0, 0, 2'b00);
        mem_rdy = 1'b1;
        cyc("ldr.r2", 4'd3, 0, 0, 0, 0, 2'b00);
        chk("ldr.adr", {3'b000, AdrSrc}, 4'd0);
        cyc("ldr.wb", 4'd4, 0, 1, 0, 0, 2'b00);

        // SUB R15 immediate: write to PC, flags untouched (S=0)
        set_instr(4'b1110, 2'b00, 6'b100100, 4'd15);
        cyc("subpc.f", 4'd0, 1, 0, 0, 1, 2'b00);
        cyc("subpc.d", 4'd1, 0, 0, 0, 0, 2'b00);
        ALUFlags = 4'b1111;
        cyc("subpc.x", 4'd7, 0, 0, 0, 0, 2'b01);
        ALUFlags = 4'b0000;
        cyc("subpc.wb", 4'd8, 1, 1, 0, 0, 2'b00);

        // ORRS immediate: N,Z <- 10, C,V kept at 10 -> flags 1010
        set_instr(4'b1110, 2'b00, 6'b111001, 4'd4);
        cyc("orrs.f", 4'd0, 1, 0, 0, 1, 2'b00);
        cyc("orrs.d", 4'd1, 0, 0, 0, 0, 2'b00);
        ALUFlags = 4'b1000;
        cyc("orrs.x", 4'd7, 0, 0, 0, 0, 2'b11);
        ALUFlags = 4'b0000;
        cyc("orrs.wb", 4'd8, 0, 1, 0, 0, 2'b00);

        // Branches against flags 1010
        set_instr(4'b1011, 2'b10, 6'b000000, 4'd0);
        cyc("blt.f", 4'd0, 1, 0, 0, 1, 2'b00);
        cyc("blt.d", 4'd1, 0, 0, 0, 0, 2'b00);
        cyc("blt.b", 4'd9, 1, 0, 0, 0, 2'b00);
        set_instr(4'b1010, 2'b10, 6'b000000, 4'd0);
        cyc("bge.f", 4'd0, 1, 0, 0, 1, 2'b00);
        cyc("bge.d", 4'd1, 0, 0, 0, 0, 2'b00);
        cyc("bge.b", 4'd9, 0, 0, 0, 0, 2'b00);
        set_instr(4'b0010, 2'b10, 6'b000000, 4'd0);
        cyc("bcs.f", 4'd0, 1, 0, 0, 1, 2'b00);
        cyc("bcs.d", 4'd1, 0, 0, 0, 0, 2'b00);
        cyc("bcs.b", 4'd9, 1, 0, 0, 0, 2'b00);

        // ANDSEQ fails (Z=0): no register write, no flag update
        set_instr(4'b0000, 2'b00, 6'b000001, 4'd15);
        cyc("andseq.f", 4'd0, 1, 0, 0, 1, 2'b00);
        cyc("andseq.d", 4'd1, 0, 0, 0, 0, 2'b00);
        ALUFlags = 4'b0100;
        cyc("andseq.x", 4'd6, 0, 0, 0, 0, 2'b10);
        ALUFlags = 4'b0000;
        cyc("andseq.wb", 4'd8, 0, 0, 0, 0, 2'b00);
        set_instr(4'b0000, 2'b10, 6'b000000, 4'd0);
        cyc("beq.f", 4'd0, 1, 0, 0, 1, 2'b00);
        cyc("beq.d", 4'd1, 0, 0, 0, 0, 2'b00);
        cyc("beq.b", 4'd9, 0, 0, 0, 0, 2'b00);

        // Undefined Op=11
        set_instr(4'b1110, 2'b11, 6'b000000, 4'd15);
        cyc("op3.f", 4'd0, 1, 0, 0, 1, 2'b00);
        cyc("op3.d", 4'd1, 0, 0, 0, 0, 2'b00);
        cyc("op3.n", 4'd0, 1, 0, 0, 1, 2'b00);

        // STR stalled in MEMWR, then asynchronous reset mid-cycle
        set_instr(4'b1110, 2'b01, 6'b011000, 4'd3);
        cyc("str.d", 4'd1, 0, 0, 0, 0, 2'b00);
        cyc("str.a", 4'd2, 0, 0, 0, 0, 2'b00);
        mem_rdy = 1'b0;
        cyc("str.w0", 4'd5, 0, 0, 1, 0, 2'b00);
        cyc("str.w1", 4'd5, 0, 0, 1, 0, 2'b00);
        #2;
        reset_n = 1'b0;
        mem_rdy = 1'b1;
        #1;
        chk("arst.state",    state,              4'd0);
        chk("arst.MemWrite", {3'b000, MemWrite}, 4'd0);
        chk("arst.IRWrite",  {3'b000, IRWrite},  4'd0);
        chk("arst.PCWrite",  {3'b000, PCWrite},  4'd0);
        @(negedge clk);
        reset_n = 1'b1;
        set_instr(4'b1110, 2'b10, 6'b000000, 4'd0);
        cyc("post.f", 4'd0, 1, 0, 0, 1, 2'b00);
        cyc("post.d", 4'd1, 0, 0, 0, 0, 2'b00);
        cyc("post.b", 4'd9, 1, 0, 0, 0, 2'b00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 The block SHALL have parameter FLAG_RESET, default 4'b0000, which is the reset value of the {N,Z,C,V} flag register.
REQ-002 clk  in  1  single clock; all state updates on its rising edge.
REQ-003 reset_n  in  1  asynchronous, active-low reset.
REQ-004 Cond  in  4  condition field of the instruction register.
REQ-005 Op  in  2  instruction class: 00 DP, 01 memory, 10 branch.
REQ-006 Funct  in  6  bit5 is the immediate flag (I); bits 4:1 are cmd; bit0 is S for DP and L for memory.
REQ-007 Rd  in  4  destination register number.
REQ-008 ALUFlags  in  4  {N,Z,C,V} from the ALU in the current cycle.
REQ-009 mem_rdy  in  1  memory access completes in this cycle.
REQ-010 PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, ALUSrcA  out  1 each  datapath enables and selects.
REQ-011 ResultSrc, ALUSrcB, ImmSrc, RegSrc, ALUControl  out  2 each  datapath selects.
REQ-012 state  out  4  current FSM state encoding, for debug.

Function
REQ-013 The FSM SHALL use these states and encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECR=6, EXECI=7, ALUWB=8, BRANCH=9; unused encodings SHALL go to FETCH.
REQ-014 Transitions SHALL be:
- FETCH->DECODE when mem_rdy=1; FETCH holds otherwise.
- DECODE: Op=01 -> MEMADR; Op=00 with I=0 -> EXECR; Op=00 with I=1 -> EXECI; Op=10 -> BRANCH; Op=11 -> FETCH.
- MEMADR: L=1 -> MEMRD; L=0 -> MEMWR.
- MEMRD -> MEMWB when mem_rdy=1, else hold.
- MEMWR -> FETCH when mem_rdy=1, else hold.
- MEMWB, ALUWB and BRANCH -> FETCH.
- EXECR and EXECI -> ALUWB.
REQ-015 FETCH SHALL drive AdrSrc=0, ALUSrcA=1, ALUSrcB=10 and ResultSrc=10; it SHALL assert IRWrite and PCWrite only in a cycle where mem_rdy=1, so each instruction increments the PC exactly once.
REQ-016 DECODE SHALL drive ALUSrcA=1, ALUSrcB=10 and ResultSrc=10, which reads PC+8 for R15.
REQ-017 MEMADR, EXECI and BRANCH SHALL drive ALUSrcA=0 and ALUSrcB=01; EXECR SHALL drive ALUSrcA=0 and ALUSrcB=00.
REQ-018 MEMRD and MEMWR SHALL drive AdrSrc=1 and ResultSrc=00; MEMWB SHALL drive ResultSrc=01; ALUWB SHALL drive ResultSrc=00; BRANCH SHALL drive ResultSrc=10.
REQ-019 Any select not listed for a state SHALL be driven to 0, and no output SHALL ever be X.
REQ-020 ImmSrc SHALL be Op, and RegSrc SHALL be {Op==01, Op==10}.
REQ-021 ALUControl SHALL be 00 (ADD) in every state except EXECR and EXECI.
REQ-022 In EXECR and EXECI, ALUControl SHALL decode cmd as: 0100->00 ADD, 0010->01 SUB, 0000->10 AND, 1100->11 ORR, any other value->00.
REQ-023 A register cond_q SHALL load CondEx in DECODE and hold it until the next DECODE.
REQ-024 CondEx SHALL use the stored flags as follows:
- EQ Z; NE !Z; CS C; CC !C; MI N; PL !N; VS V; VC !V.
- HI C&!Z; LS !C|Z; GE N==V; LT N!=V; GT !Z&(N==V); LE Z|(N!=V).
- AL 1; 1111 -> 0.
REQ-025 The flag register SHALL update only in EXECR or EXECI, and only when cond_q=1:
- N,Z <= ALUFlags[3:2] if S=1.
- C,V <= ALUFlags[1:0] if S=1 and cmd decodes to ADD or SUB.
REQ-026 RegWrite SHALL equal cond_q in MEMWB and in ALUWB, and 0 in all other states.
REQ-027 MemWrite SHALL equal cond_q throughout MEMWR, held until mem_rdy=1.
REQ-028 PCWrite outside FETCH SHALL equal cond_q in BRANCH, and cond_q in MEMWB or ALUWB when Rd=1111.
REQ-029 A failed condition SHALL still walk the full state path with all writes suppressed.

Reset
REQ-030 While reset_n=0, regardless of clk:
- state=FETCH, flags=FLAG_RESET, cond_q=0.
REQ-031 Because state=FETCH during reset, the outputs SHALL be the FETCH values with mem_rdy masked, so that PCWrite=IRWrite=MemWrite=RegWrite=0.
REQ-032 Reset asserted mid-instruction SHALL abort it with no further writes; the first FETCH after release SHALL start a new instruction.

Verification
REQ-033 Reset: assert reset_n=0 mid-MEMWR -> state=0 and MemWrite=0 immediately, without a clock edge.
REQ-034 ADDS R1,R2,R3 (Cond=1110, Op=00, Funct=001001), ALUFlags=0110, mem_rdy=1:
- states 0,1,6,8,0.
- ALUControl=00 in EXECR.
- flags=0110 after EXECR.
- RegWrite=1 in ALUWB.
REQ-035 LDR (Op=01, Funct=011001) with mem_rdy low for 2 cycles in MEMRD:
- states 0,1,2,3,3,3,4,0.
- RegWrite=1 only in MEMWB.
REQ-036 STREQ (Cond=0000) with Z=0 -> states 0,1,2,5,0 with MemWrite=0 throughout.
REQ-037 Conditional branches:
- B (Op=10, Cond=1110) -> PCWrite=1 in BRANCH.
- BNE with Z=1 -> PCWrite=0.
REQ-038 Write to R15 and undefined Op:
- SUB R15 with I=1 -> states 0,1,7,8, with PCWrite=RegWrite=1 in ALUWB.
- Op=11 -> DECODE goes to FETCH with no writes.
